// File: rtl/cv32e40p_fault_pkg.sv
// Shared constants and types for the fault monitor: fault class layout,
// register offsets and a byte-lane mask helper.
package cv32e40p_fault_pkg;

  // Width of each fault class as presented by the core
  localparam int unsigned DIV_W   = 2;
  localparam int unsigned MEM_W   = 15;
  localparam int unsigned ECC_W   = 3;
  localparam int unsigned MULT_W  = 9;
  localparam int unsigned FAULT_W = DIV_W + MEM_W + ECC_W + MULT_W;

  // Position of each class inside the packed STATUS vector
  localparam int unsigned DIV_LSB  = 0;
  localparam int unsigned MEM_LSB  = DIV_LSB + DIV_W;
  localparam int unsigned ECC_LSB  = MEM_LSB + MEM_W;
  localparam int unsigned MULT_LSB = ECC_LSB + ECC_W;

  // Register byte offsets relative to BASE_ADDR
  localparam logic [4:0] OFF_STATUS   = 5'h00;
  localparam logic [4:0] OFF_PEND     = 5'h04;
  localparam logic [4:0] OFF_IRQ_EN   = 5'h08;
  localparam logic [4:0] OFF_CNT_DIV  = 5'h0C;
  localparam logic [4:0] OFF_CNT_MEM  = 5'h10;
  localparam logic [4:0] OFF_CNT_ECC  = 5'h14;
  localparam logic [4:0] OFF_CNT_MULT = 5'h18;
  localparam logic [4:0] OFF_RSVD     = 5'h1C;

  typedef enum logic [1:0] {
    FC_DIV  = 2'd0,
    FC_MEM  = 2'd1,
    FC_ECC  = 2'd2,
    FC_MULT = 2'd3
  } fault_class_e;

  // Expand four byte enables into a 32-bit bit mask
  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/cv32e40p_fault_counter.sv
// Saturating event counter for one fault class.
module cv32e40p_fault_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 inc_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  logic [CNT_WIDTH-1:0] count_q;

  // Clear restarts the count, keeping a coincident event; otherwise count up and stick at all-ones
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= inc_i ? CNT_WIDTH'(1) : '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cv32e40p_fault_monitor.sv
// Fault monitor: sticky fault status, per-class edge counters and a maskable
// interrupt, all exposed through an always-ready OBI-style register port.
module cv32e40p_fault_monitor
  import cv32e40p_fault_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DIV_W-1:0]  div_tmr_err_i,
  input  logic [MEM_W-1:0]  mem_err_i,
  input  logic [ECC_W-1:0]  ecc_err_i,
  input  logic [MULT_W-1:0] tmr_mult_err_i,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [31:0]       addr_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              irq_o
);

  logic [FAULT_W-1:0]   fault_vec;
  logic [FAULT_W-1:0]   status_q;
  logic [FAULT_W-1:0]   status_d;
  logic [FAULT_W-1:0]   status_clr;
  logic [3:0]           class_or;
  logic [3:0]           class_or_q;
  logic [3:0]           class_evt;
  logic [3:0]           pend_q;
  logic [3:0]           pend_d;
  logic [3:0]           pend_clr;
  logic [3:0]           irq_en_q;
  logic                 irq_en_we;
  logic [3:0]           cnt_clr;
  logic [CNT_WIDTH-1:0] cnt_q [4];
  logic [31:0]          cnt_ext [4];
  logic [31:0]          offset;
  logic [4:0]           reg_off;
  logic [31:0]          be_mask;
  logic                 in_range;
  logic                 wr_acc;
  logic                 cnt_wr;
  logic                 rd_acc;
  logic [31:0]          rd_value;
  logic                 unused_bits;

  assign gnt_o = req_i;

  // Pack the fault inputs into STATUS layout and detect rising edges of each class
  always_comb begin
    fault_vec          = {tmr_mult_err_i, ecc_err_i, mem_err_i, div_tmr_err_i};
    class_or           = '0;
    class_or[FC_DIV]   = |div_tmr_err_i;
    class_or[FC_MEM]   = |mem_err_i;
    class_or[FC_ECC]   = |ecc_err_i;
    class_or[FC_MULT]  = |tmr_mult_err_i;
    class_evt          = class_or & ~class_or_q;
  end

  // Decode the register access and derive clear/write strobes; new faults win over clears
  always_comb begin
    offset     = addr_i - BASE_ADDR;
    reg_off    = {offset[4:2], 2'b00};
    in_range   = (offset[31:5] == '0);
    be_mask    = byte_mask(be_i);
    wr_acc     = req_i && we_i && in_range;
    rd_acc     = req_i && !we_i;
    cnt_wr     = wr_acc && (be_i != 4'b0000);
    status_clr = '0;
    pend_clr   = '0;
    irq_en_we  = 1'b0;
    cnt_clr    = '0;
    if (wr_acc && (reg_off == OFF_STATUS)) begin
      status_clr = wdata_i[FAULT_W-1:0] & be_mask[FAULT_W-1:0];
    end
    if (wr_acc && (reg_off == OFF_PEND)) begin
      pend_clr = wdata_i[3:0] & be_mask[3:0];
    end
    if (wr_acc && (reg_off == OFF_IRQ_EN) && be_i[0]) begin
      irq_en_we = 1'b1;
    end
    cnt_clr[FC_DIV]  = cnt_wr && (reg_off == OFF_CNT_DIV);
    cnt_clr[FC_MEM]  = cnt_wr && (reg_off == OFF_CNT_MEM);
    cnt_clr[FC_ECC]  = cnt_wr && (reg_off == OFF_CNT_ECC);
    cnt_clr[FC_MULT] = cnt_wr && (reg_off == OFF_CNT_MULT);
    status_d   = (status_q & ~status_clr) | fault_vec;
    pend_d     = (pend_q & ~pend_clr) | class_evt;
  end

  // Read mux over the current (pre-update) register values, counters zero-extended
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      cnt_ext[c] = '0;
      cnt_ext[c][CNT_WIDTH-1:0] = cnt_q[c];
    end
    rd_value = '0;
    if (in_range) begin
      case (reg_off)
        OFF_STATUS:   rd_value = {{(32-FAULT_W){1'b0}}, status_q};
        OFF_PEND:     rd_value = {28'h0, pend_q};
        OFF_IRQ_EN:   rd_value = {28'h0, irq_en_q};
        OFF_CNT_DIV:  rd_value = cnt_ext[FC_DIV];
        OFF_CNT_MEM:  rd_value = cnt_ext[FC_MEM];
        OFF_CNT_ECC:  rd_value = cnt_ext[FC_ECC];
        OFF_CNT_MULT: rd_value = cnt_ext[FC_MULT];
        default:      rd_value = '0;
      endcase
    end
  end

  // State registers, interrupt and the single-cycle response
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      status_q   <= '0;
      class_or_q <= '0;
      pend_q     <= '0;
      irq_en_q   <= '0;
      irq_o      <= 1'b0;
      rvalid_o   <= 1'b0;
      rdata_o    <= '0;
    end else begin
      status_q   <= status_d;
      class_or_q <= class_or;
      pend_q     <= pend_d;
      if (irq_en_we) begin
        irq_en_q <= wdata_i[3:0];
      end
      irq_o      <= |(pend_d & irq_en_q);
      rvalid_o   <= req_i;
      rdata_o    <= rd_acc ? rd_value : '0;
    end
  end

  // One saturating counter per fault class
  for (genvar c = 0; c < 4; c++) begin : g_cnt
    cv32e40p_fault_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_counter (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (class_evt[c]),
      .clr_i   (cnt_clr[c]),
      .count_o (cnt_q[c])
    );
  end

  assign unused_bits = ^{wdata_i[31:FAULT_W], be_mask[31:FAULT_W], offset[1:0]};

endmodule
